// File: rtl/regseq_pkg.sv
// Shared types and defaults for the register-file operand-fetch / write-back sequencer.
package regseq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ_A   = 3'd1,
    S_READ_B   = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_RES = 3'd4,
    S_WRITE    = 3'd5
  } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Sole master of a single-ported register file: fetches rs1/rs2 over two cycles,
// hands them to execute with valid/ready, then writes the result back to rd.
module regfile_sequencer
  import regseq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_wb,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              wb_q, wb_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  // Registered "out of reset" flag keeps req_ready low during reset without
  // a combinational path from rst_n to the output.
  logic              init_q;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == ADDR_W'(ZERO_ADDR));
  endfunction

  function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] data);
    return is_zero_reg(addr) ? '0 : data;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      wdata_q <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      wdata_q <= wdata_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && init_q) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          rd_d    = req_rd;
          wb_d    = req_wb;
          state_d = S_READ_A;
        end
      end
      S_READ_A: begin
        op_a_d  = read_value(rs1_q, rf_rdata);
        state_d = S_READ_B;
      end
      S_READ_B: begin
        op_b_d  = read_value(rs2_q, rf_rdata);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (op_ready) begin
          state_d = wb_q ? S_WAIT_RES : S_IDLE;
        end
      end
      S_WAIT_RES: begin
        if (res_valid) begin
          wdata_d = res_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state and latched fields.
  always_comb begin
    req_ready = 1'b0;
    op_valid  = 1'b0;
    rf_addr   = '0;
    rf_we     = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:   req_ready = init_q;
      S_READ_A: rf_addr   = rs1_q;
      S_READ_B: rf_addr   = rs2_q;
      S_ISSUE:  op_valid  = 1'b1;
      S_WRITE: begin
        rf_addr = rd_q;
        rf_we   = !is_zero_reg(rd_q);
      end
      default: ;
    endcase
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign rf_wdata = wdata_q;

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Single-issue operand-fetch / write-back sequencer that is the sole master of the 32×32 single-ported register file (one address, combinational read, write on clk rising edge). It accepts a register-level request (rs1, rs2, rd), reads both source operands over two cycles through the single port, and hands them to the execute stage with a valid/ready handshake. It then waits for the result and writes it back to rd. Only one request is in flight, so no forwarding or hazard logic is needed.

## Interface
Parameters:
- DATA_W, 32, register/operand width
- ADDR_W, 5, register address width
- ZERO_REG, 1, when 1 register 0 reads as 0 and writes to it are suppressed

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_rs1  in  ADDR_W  source A register
- req_rs2  in  ADDR_W  source B register
- req_rd  in  ADDR_W  destination register
- req_wb  in  1  1 = result must be written back
- op_valid  out  1  op_a/op_b valid for execute
- op_ready  in  1  execute accepts operands
- op_a  out  DATA_W  operand A
- op_b  out  DATA_W  operand B
- res_valid  in  1  execute result valid (single-cycle pulse sufficient)
- res_data  in  DATA_W  execute result
- rf_addr  out  ADDR_W  register file address
- rf_we  out  1  register file write enable
- rf_wdata  out  DATA_W  register file write data
- rf_rdata  in  DATA_W  register file combinational read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, READ_A, READ_B, ISSUE, WAIT_RES, WRITE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch rs1, rs2, rd, wb, then go to READ_A.
- READ_A: rf_addr=rs1; capture rf_rdata into op_a; go to READ_B.
- READ_B: rf_addr=rs2; capture into op_b; go to ISSUE.
- ISSUE: op_valid=1; op_a/op_b held stable until op_ready. On op_ready: if wb go to WAIT_RES, else go to IDLE.
- WAIT_RES: on res_valid, latch res_data into rf_wdata register and go to WRITE.
- WRITE: rf_addr=rd, rf_we=1 (0 if ZERO_REG and rd==0); go to IDLE.
- rf_addr=0 and rf_we=0 in IDLE, ISSUE and WAIT_RES.
- ZERO_REG=1: a read of register 0 captures 0 regardless of rf_rdata.
- rs1==rs2: still two read cycles; both operands are equal.
- res_valid outside WAIT_RES is ignored. Request inputs outside IDLE are ignored.
- Reset (rst_n low, at any time, mid-operation included): state=IDLE; op_a, op_b, rf_wdata, latched fields = 0; op_valid=0; rf_we=0; rf_addr=0; busy=0; req_ready=0 while rst_n low, 1 from first cycle after release. An in-flight request is dropped with no write.

## Timing
- Request accepted at edge T0; READ_A cycle T0+1; READ_B T0+2; op_valid first high T0+3.
- With op_ready=1 at T0+3 and res_valid at T0+4: WRITE at T0+5 (register updated at end of T0+5), req_ready=1 at T0+6.
- No-writeback request with op_ready=1 immediately: req_ready=1 at T0+4.
- Minimum request-to-request spacing: 4 cycles (no wb), 6 cycles (wb).
- op_valid, once high, does not drop until the op_ready handshake. Operands do not change while op_valid=1.
- All outputs are decoded from registered state. There is no combinational path from any input to any output.

## Structure
- Package regseq_pkg: DATA_W/ADDR_W defaults, state enum (6 values, 3-bit encoding), ZERO_ADDR constant.
- Single module with one FSM; no sub-module is needed. Top-level integration instantiates it beside the register file, with rf_* wired to address/write_enable/data_in/data_out.

## Test plan
- Preload r3=0x11, r4=0x22. Request rs1=3, rs2=4, rd=5, wb=1; op_ready=1; res=0x33 at first WAIT_RES cycle. Expect op_a=0x11, op_b=0x22 at T0+3, and r5=0x33 written at T0+5.
- ZERO_REG: request rs1=0, rs2=0, rd=0, with the bus model returning 0xFFFF_FFFF. Expect op_a=op_b=0 and rf_we never asserted.
- Backpressure: hold op_ready=0 for 7 cycles. Expect op_valid steady at 1, operands stable, req_ready=0 throughout.
- wb=0 request followed by a second back-to-back request. Expect the second accepted at T0+4 and no rf_we pulse.
- Spurious res_valid in IDLE/ISSUE: expect no write. Delayed res_valid by 10 cycles: expect a single write afterwards.
- Assert rst_n low during WAIT_RES. Expect immediate IDLE, all outputs 0, no write to rd, and req_ready=1 the cycle after release.
